// File: rtl/tnoc_pkg.sv
// -----------------------------------------------------------------------------
// tnoc_pkg
// Shared definitions for the router output-port allocator:
//   PORTS                 number of router ports (4 mesh directions + local)
//   tnoc_port_type        port identifiers, also used as the round-robin pointer
//   tnoc_config           router configuration (virtual channel count, data width)
//   tnoc_arbiter_state_e  per-VC packet arbiter state
//   tnoc_rr_pick          one-hot round-robin pick, search starts after the pointer
//   tnoc_onehot_to_port   encodes a one-hot port vector into a port identifier
// -----------------------------------------------------------------------------
package tnoc_pkg;

    localparam int PORTS = 5;

    typedef enum logic [2:0] {
        TNOC_PORT_X_PLUS  = 3'd0,
        TNOC_PORT_X_MINUS = 3'd1,
        TNOC_PORT_Y_PLUS  = 3'd2,
        TNOC_PORT_Y_MINUS = 3'd3,
        TNOC_PORT_LOCAL   = 3'd4
    } tnoc_port_type;

    typedef struct packed {
        int virtual_channels;
        int data_width;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{
        virtual_channels: 2,
        data_width:       32
    };

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } tnoc_arbiter_state_e;

    // Scans ports pointer+1, pointer+2, ... wrapping 4 -> 0, and returns the
    // first requester as a one-hot vector (all zero when nobody requests).
    // An out-of-range pointer restarts the scan at port 0.
    function automatic logic [PORTS-1:0] tnoc_rr_pick(
        input logic [PORTS-1:0] request,
        input logic [2:0]       pointer
    );
        logic [PORTS-1:0] pick;
        logic [2:0]       index;
        pick  = '0;
        index = pointer;
        for (int i = 0; i < PORTS; i++) begin
            index = (index >= 3'd4) ? 3'd0 : index + 3'd1;
            if (pick == '0 && request[index]) begin
                pick[index] = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic tnoc_port_type tnoc_onehot_to_port(input logic [PORTS-1:0] onehot);
        logic [2:0] index;
        index = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (onehot[i]) begin
                index = index | 3'(i);
            end
        end
        return tnoc_port_type'(index);
    endfunction

endpackage

// File: rtl/tnoc_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tnoc_packet_arbiter
// Packet-granular round-robin arbiter for one virtual channel of one output.
// Once a port is granted it keeps the VC until it signals the tail flit with
// i_free; only then are requests considered again (same cycle, no bubble).
// The pointer always equals the current owner, so a freeing owner that
// re-requests is searched last and wins only when it is the sole requester.
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   i_request  [p]: port p requests this VC (already masked for absent ports)
//   i_free     [p]: port p transferred its tail flit; releases if p is owner
//   o_grant    [p]: port p owns this VC (registered, one-hot or zero)
// -----------------------------------------------------------------------------
module tnoc_packet_arbiter
    import tnoc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] i_request,
    input  logic [PORTS-1:0] i_free,
    output logic [PORTS-1:0] o_grant
);

    tnoc_arbiter_state_e r_state;
    tnoc_arbiter_state_e w_next_state;
    logic [PORTS-1:0]    r_grant;
    logic [PORTS-1:0]    w_next_grant;
    tnoc_port_type       r_ptr;
    tnoc_port_type       w_next_ptr;
    logic [PORTS-1:0]    w_pick;
    logic                w_release;

    // Only the owner's i_free counts; frees from other ports or on an idle VC
    // are ignored.
    assign w_release = (r_state == ARB_LOCKED) && ((i_free & r_grant) != '0);
    assign w_pick    = tnoc_rr_pick(i_request, r_ptr);

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_ptr   = r_ptr;
        if (r_state == ARB_IDLE || w_release) begin
            if (w_pick != '0) begin
                w_next_state = ARB_LOCKED;
                w_next_grant = w_pick;
                w_next_ptr   = tnoc_onehot_to_port(w_pick);
            end else begin
                w_next_state = ARB_IDLE;
                w_next_grant = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the async reset drops ownership immediately and
    // parks the pointer on port 4 so port 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_ptr   <= TNOC_PORT_LOCAL;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_ptr   <= w_next_ptr;
        end
    end

    assign o_grant = r_grant;

endmodule

// File: rtl/tnoc_output_port_allocator.sv
// -----------------------------------------------------------------------------
// tnoc_output_port_allocator
// Allocates one router output port among the input blocks, per virtual
// channel, holding each grant for a whole packet, and picks each cycle which
// owning VC drives the output flit mux (lowest eligible VC first).
// Ports (vectors indexed [v*PORTS+p] for VC v, input port p):
//   clk            clock
//   rst_n          asynchronous active-low reset
//   i_request      port p requests this output on VC v
//   i_free         port p's tail flit on VC v transferred; release
//   i_flit_valid   port p has a flit valid on VC v
//   i_vc_ready     downstream VC v can accept a flit this cycle
//   o_grant        port p owns VC v (registered, one-hot per VC)
//   o_vc_select    one-hot VC forwarded this cycle, 0 if none eligible
//   o_port_select  one-hot owner of the selected VC, 0 if none eligible
// -----------------------------------------------------------------------------
module tnoc_output_port_allocator
    import tnoc_pkg::*;
#(
    parameter tnoc_config       CONFIG          = TNOC_DEFAULT_CONFIG,
    parameter logic [PORTS-1:0] AVAILABLE_PORTS = 5'b11111,
    localparam int              CHANNELS        = CONFIG.virtual_channels
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*PORTS-1:0] i_request,
    input  logic [CHANNELS*PORTS-1:0] i_free,
    input  logic [CHANNELS*PORTS-1:0] i_flit_valid,
    input  logic [CHANNELS-1:0]       i_vc_ready,
    output logic [CHANNELS*PORTS-1:0] o_grant,
    output logic [CHANNELS-1:0]       o_vc_select,
    output logic [PORTS-1:0]          o_port_select
);

    logic [CHANNELS*PORTS-1:0] w_request;
    logic [CHANNELS*PORTS-1:0] w_grant;
    logic [CHANNELS-1:0]       w_eligible;
    logic [CHANNELS-1:0]       w_vc_select;
    logic [PORTS-1:0]          w_port_select;

    // Absent ports can never win, so they can never own a VC either.
    assign w_request = i_request & {CHANNELS{AVAILABLE_PORTS}};

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        tnoc_packet_arbiter u_arbiter (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_request (w_request[v*PORTS+:PORTS]),
            .i_free    (i_free[v*PORTS+:PORTS]),
            .o_grant   (w_grant[v*PORTS+:PORTS])
        );

        // A non-zero grant means LOCKED; the owner's flit must be valid and
        // the downstream VC must have room.
        assign w_eligible[v] = ((w_grant[v*PORTS+:PORTS] & i_flit_valid[v*PORTS+:PORTS]) != '0)
                               && i_vc_ready[v];
    end

    always_comb begin
        w_vc_select   = '0;
        w_port_select = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            if (w_vc_select == '0 && w_eligible[v]) begin
                w_vc_select[v] = 1'b1;
                w_port_select  = w_grant[v*PORTS+:PORTS];
            end
        end
    end

    assign o_grant       = w_grant;
    assign o_vc_select   = w_vc_select;
    assign o_port_select = w_port_select;

endmodule
